// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: steers a valid/ready stream to one of NCH channels,
// chosen per beat by in_sel, through a single registered output stage.
// Beats whose select names no existing channel are dropped and counted
// in a saturating counter.
module demux_1xn_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SELW-1:0]  in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  drop_cnt
);

    // One extra bit so NCH == 2**SELW is representable.
    localparam logic [SELW:0] LP_NCH = (SELW+1)'(NCH);

    logic             r_hold_v;
    logic [SELW-1:0]  r_hold_sel;
    logic [WIDTH-1:0] r_hold_data;
    logic [CNTW-1:0]  r_cnt;

    logic             w_drain;
    logic             w_accept;
    logic             w_sel_ok;
    logic             w_cnt_sat;

    // Held beat leaves when its own channel is ready; other channels' ready bits are ignored.
    always_comb begin
        w_drain = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (r_hold_v && (r_hold_sel == SELW'(k)) && out_ready[k]) begin
                w_drain = 1'b1;
            end
        end
    end

    // Input handshake and select legality.
    always_comb begin
        in_ready  = !r_hold_v || w_drain;
        w_accept  = in_valid && in_ready;
        w_sel_ok  = ({1'b0, in_sel} < LP_NCH);
        w_cnt_sat = (r_cnt == '1);
    end

    // One-hot channel valid decoded from the held select.
    always_comb begin
        out_valid = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            out_valid[k] = r_hold_v && (r_hold_sel == SELW'(k));
        end
    end

    // Payload and counter are presented straight from their registers.
    always_comb begin
        out_data = r_hold_data;
        drop_cnt = r_cnt;
    end

    // Holding register: load on a legal accept, otherwise empty on drain.
    // A dropped beat falls into the drain branch, so a held beat that
    // drains in the same cycle is still released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v    <= 1'b0;
            r_hold_sel  <= '0;
            r_hold_data <= '0;
        end else if (w_accept && w_sel_ok) begin
            r_hold_v    <= 1'b1;
            r_hold_sel  <= in_sel;
            r_hold_data <= in_data;
        end else if (w_drain) begin
            r_hold_v    <= 1'b0;
        end
    end

    // Saturating count of beats dropped for an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && !w_sel_ok && !w_cnt_sat) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: three instances (default 4-channel, 3-channel
// with illegal selects, 3-channel with a 2-bit drop counter) driven from a
// table of hand-computed vectors plus reset sequences.
module tb_demux_1xn_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // dut0: defaults (WIDTH 8, NCH 4, SELW 2, CNTW 8)
    logic       v0, r0;
    logic [1:0] s0;
    logic [7:0] d0, od0, c0;
    logic [3:0] ov0, or0;

    // dut1: NCH 3
    logic       v1, r1;
    logic [1:0] s1;
    logic [7:0] d1, od1, c1;
    logic [2:0] ov1, or1;

    // dut2: NCH 3, CNTW 2
    logic       v2, r2;
    logic [1:0] s2, c2;
    logic [7:0] d2, od2;
    logic [2:0] ov2, or2;

    demux_1xn_stream #(.WIDTH(8), .NCH(4), .SELW(2), .CNTW(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_sel(s0),
        .in_data(d0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .drop_cnt(c0)
    );

    demux_1xn_stream #(.WIDTH(8), .NCH(3), .SELW(2), .CNTW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_sel(s1),
        .in_data(d1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .drop_cnt(c1)
    );

    demux_1xn_stream #(.WIDTH(8), .NCH(3), .SELW(2), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_sel(s2),
        .in_data(d2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .drop_cnt(c2)
    );

    typedef struct {
        int unsigned dut;
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [7:0]  exp_data;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int unsigned dut, logic v, logic [1:0] sel, logic [7:0] data,
                                logic [3:0] ordy, logic exp_rdy, logic [3:0] exp_ov,
                                logic [7:0] exp_data, logic [7:0] exp_cnt);
        vec_t t;
        t.dut = dut; t.v = v; t.sel = sel; t.data = data; t.ordy = ordy;
        t.exp_rdy = exp_rdy; t.exp_ov = exp_ov; t.exp_data = exp_data; t.exp_cnt = exp_cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        case (t.dut)
            0: begin v0 = t.v; s0 = t.sel; d0 = t.data; or0 = t.ordy; end
            1: begin v1 = t.v; s1 = t.sel; d1 = t.data; or1 = t.ordy[2:0]; end
            default: begin v2 = t.v; s2 = t.sel; d2 = t.data; or2 = t.ordy[2:0]; end
        endcase
    endtask

    task automatic sample(input int unsigned dut, output logic rdy, output logic [3:0] ov,
                          output logic [7:0] od, output logic [7:0] cnt);
        case (dut)
            0: begin rdy = r0; ov = ov0; od = od0; cnt = c0; end
            1: begin rdy = r1; ov = {1'b0, ov1}; od = od1; cnt = c1; end
            default: begin rdy = r2; ov = {1'b0, ov2}; od = od2; cnt = {6'b0, c2}; end
        endcase
    endtask

    initial begin
        logic       rdy;
        logic [3:0] ov;
        logic [7:0] od, cnt;

        // dut0: streaming, stall, idle-while-stalled, drain-only, ignored ready bits
        vecs.push_back(mk(0, 1, 0, 8'h11, 4'b1111, 1, 4'b0001, 8'h11, 0));
        vecs.push_back(mk(0, 1, 1, 8'h22, 4'b1111, 1, 4'b0010, 8'h22, 0));
        vecs.push_back(mk(0, 1, 2, 8'h33, 4'b1111, 1, 4'b0100, 8'h33, 0));
        vecs.push_back(mk(0, 1, 3, 8'h44, 4'b1111, 1, 4'b1000, 8'h44, 0));
        vecs.push_back(mk(0, 1, 2, 8'h5C, 4'b1111, 1, 4'b0100, 8'h5C, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 0, 8'h77, 4'b1011, 0, 4'b0100, 8'h5C, 0));
        vecs.push_back(mk(0, 1, 0, 8'h77, 4'b1111, 1, 4'b0001, 8'h77, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b1110, 0, 4'b0001, 8'h77, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b0001, 1, 4'b0000, 8'h77, 0));
        vecs.push_back(mk(0, 1, 3, 8'hF0, 4'b0000, 1, 4'b1000, 8'hF0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hAB, 4'b0111, 0, 4'b1000, 8'hF0, 0));
        // dut1: drops, legal beat, blocked drop, drop while draining, top channel
        vecs.push_back(mk(1, 1, 3, 8'h10, 4'b0111, 1, 4'b0000, 8'h00, 1));
        vecs.push_back(mk(1, 1, 3, 8'h20, 4'b0111, 1, 4'b0000, 8'h00, 2));
        vecs.push_back(mk(1, 1, 3, 8'h30, 4'b0111, 1, 4'b0000, 8'h00, 3));
        vecs.push_back(mk(1, 1, 1, 8'h9E, 4'b0111, 1, 4'b0010, 8'h9E, 3));
        vecs.push_back(mk(1, 1, 3, 8'h40, 4'b0101, 0, 4'b0010, 8'h9E, 3));
        vecs.push_back(mk(1, 1, 3, 8'h40, 4'b0111, 1, 4'b0000, 8'h9E, 4));
        vecs.push_back(mk(1, 1, 2, 8'h5A, 4'b0000, 1, 4'b0100, 8'h5A, 4));
        // dut2: saturation of a 2-bit drop counter, then a legal beat
        vecs.push_back(mk(2, 1, 3, 8'h01, 4'b0111, 1, 4'b0000, 8'h00, 1));
        vecs.push_back(mk(2, 1, 3, 8'h02, 4'b0111, 1, 4'b0000, 8'h00, 2));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2, 1, 3, 8'h03, 4'b0111, 1, 4'b0000, 8'h00, 3));
        vecs.push_back(mk(2, 1, 0, 8'h66, 4'b0111, 1, 4'b0001, 8'h66, 3));

        // Reset with a beat offered: nothing may be captured while rst_n is low
        rst_n = 1'b0;
        v0 = 1; s0 = 1; d0 = 8'hAA; or0 = 4'b0000;
        v1 = 0; s1 = 0; d1 = 0; or1 = 3'b000;
        v2 = 0; s2 = 0; d2 = 0; or2 = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(ov0), 32'h0);
        check("reset out_data", 32'(od0), 32'h0);
        check("reset drop_cnt", 32'(c0), 32'h0);
        check("reset in_ready", 32'(r0), 32'h1);
        check("reset dut1 drop_cnt", 32'(c1), 32'h0);
        check("reset dut2 drop_cnt", 32'(c2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first accept out_valid", 32'(ov0), 32'h2);
        check("first accept out_data", 32'(od0), 32'hAA);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            sample(vecs[i].dut, rdy, ov, od, cnt);
            check($sformatf("vec%0d in_ready", i), 32'(rdy), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            sample(vecs[i].dut, rdy, ov, od, cnt);
            check($sformatf("vec%0d out_valid", i), 32'(ov), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_data", i), 32'(od), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d drop_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
        end

        // dut0 is still stalled holding (3, F0); reset between edges drops it at once
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(ov0), 32'h0);
        check("async reset out_data", 32'(od0), 32'h0);
        check("async reset in_ready", 32'(r0), 32'h1);
        check("async reset dut1 out_valid", 32'(ov1), 32'h0);
        check("async reset dut1 drop_cnt", 32'(c1), 32'h0);
        check("async reset dut2 drop_cnt", 32'(c2), 32'h0);
        #1;
        rst_n = 1'b1;
        v0 = 0; v1 = 0; v2 = 0;
        @(posedge clk);
        #1;
        check("after reset beat lost", 32'(ov0), 32'h0);
        check("after reset drop_cnt", 32'(c0), 32'h0);
        v0 = 1; s0 = 2; d0 = 8'h3C; or0 = 4'b1111;
        @(posedge clk);
        #1;
        check("post reset accept out_valid", 32'(ov0), 32'h4);
        check("post reset accept out_data", 32'(od0), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
